// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-channel TDM demultiplexer (receive side of the 4:1 mux path).
// Aligns to a frame-sync marker, deserialises four WIDTH-bit slots (a, b, c, d,
// MSB first) from one serial wire and presents them in parallel once per frame.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid          din/frame_sync are meaningful this cycle; low freezes all state
//   frame_sync        marks the first bit of slot a
//   din               serial data, MSB of each word first
//   out_a..out_d      channel words of the last completed frame
//   out_valid         one-cycle pulse when out_a..out_d update
//   slot              {s1,s2} of the slot the next accepted bit belongs to
//   locked            high while framed
//   sync_err          one-cycle pulse on an unexpected frame_sync while locked
module tdm_demux4 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             frame_sync,
   input  logic             din,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic [WIDTH-1:0] out_c,
   output logic [WIDTH-1:0] out_d,
   output logic             out_valid,
   output logic [1:0]       slot,
   output logic             locked,
   output logic             sync_err
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   // The newest bit arrives on din, so only WIDTH-1 earlier bits need storage.
   localparam int unsigned SHR_W = WIDTH - 1;

   typedef enum logic {
      HUNT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       slot_n;
   logic [SHR_W-1:0] shreg, shreg_n;
   logic [WIDTH-1:0] hold_a, hold_a_n;
   logic [WIDTH-1:0] hold_b, hold_b_n;
   logic [WIDTH-1:0] hold_c, hold_c_n;
   logic [WIDTH-1:0] out_a_n, out_b_n, out_c_n, out_d_n;
   logic             out_valid_n;
   logic             sync_err_n;
   logic             locked_n;

   logic [WIDTH-1:0] word;
   logic             last_bit;
   logic             frame_start;

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= HUNT;
         cnt       <= '0;
         slot      <= 2'b00;
         shreg     <= '0;
         hold_a    <= '0;
         hold_b    <= '0;
         hold_c    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_c     <= '0;
         out_d     <= '0;
         out_valid <= 1'b0;
         sync_err  <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         slot      <= slot_n;
         shreg     <= shreg_n;
         hold_a    <= hold_a_n;
         hold_b    <= hold_b_n;
         hold_c    <= hold_c_n;
         out_a     <= out_a_n;
         out_b     <= out_b_n;
         out_c     <= out_c_n;
         out_d     <= out_d_n;
         out_valid <= out_valid_n;
         sync_err  <= sync_err_n;
         locked    <= locked_n;
      end
   end

   // Next-state, deserialiser and frame-assembly logic.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      slot_n      = slot;
      shreg_n     = shreg;
      hold_a_n    = hold_a;
      hold_b_n    = hold_b;
      hold_c_n    = hold_c;
      out_a_n     = out_a;
      out_b_n     = out_b;
      out_c_n     = out_c;
      out_d_n     = out_d;
      out_valid_n = 1'b0;
      sync_err_n  = 1'b0;

      word        = {shreg, din};
      last_bit    = (cnt == CNT_W'(WIDTH - 1));
      frame_start = (cnt == '0) && (slot == 2'b00);

      if (in_valid) begin
         case (state)
            HUNT: begin
               // Sync bit is the MSB of slot a; everything else is discarded.
               if (frame_sync) begin
                  shreg_n = word[SHR_W-1:0];
                  cnt_n   = CNT_W'(1);
                  slot_n  = 2'b00;
                  state_n = RUN;
               end
            end
            RUN: begin
               shreg_n = word[SHR_W-1:0];
               if (frame_sync && !frame_start) begin
                  // Realign: abandon the partial frame, this bit opens a new slot a.
                  sync_err_n = 1'b1;
                  cnt_n      = CNT_W'(1);
                  slot_n     = 2'b00;
               end else if (last_bit) begin
                  cnt_n  = '0;
                  slot_n = slot + 2'b01;
                  case (slot)
                     2'b00: hold_a_n = word;
                     2'b01: hold_b_n = word;
                     2'b10: hold_c_n = word;
                     default: begin
                        // Slot d completes the frame; it bypasses the holding stage.
                        out_a_n     = hold_a;
                        out_b_n     = hold_b;
                        out_c_n     = hold_c;
                        out_d_n     = word;
                        out_valid_n = 1'b1;
                     end
                  endcase
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            default: state_n = HUNT;
         endcase
      end

      locked_n = (state_n == RUN);
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- scoreboard bench for tdm_demux4 (WIDTH=8).
// Expected frames are queued when a frame is driven and compared when out_valid fires.
module tb_tdm_demux4;

   localparam int unsigned W  = 8;
   localparam int unsigned FB = 4 * W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         frame_sync = 1'b0;
   logic         din = 1'b0;
   logic [W-1:0] out_a, out_b, out_c, out_d;
   logic         out_valid;
   logic [1:0]   slot;
   logic         locked;
   logic         sync_err;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] c;
      logic [W-1:0] d;
   } frame_t;

   frame_t exp_q[$];
   frame_t mon_e;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;
   int valid_cyc = 0;
   int n_valid  = 0;
   int n_serr   = 0;
   int drive_cyc = 0;
   int st_cyc   = 0;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .frame_sync (frame_sync),
      .din        (din),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_c      (out_c),
      .out_d      (out_d),
      .out_valid  (out_valid),
      .slot       (slot),
      .locked     (locked),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Output monitor: pops the scoreboard on every out_valid pulse.
   always @(posedge clk) begin
      #1;
      if (out_valid) begin
         valid_cyc = cyc;
         n_valid++;
         if (exp_q.size() == 0) begin
            check("spurious_valid", 32'(out_valid), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("out_a", 32'(out_a), 32'(mon_e.a));
            check("out_b", 32'(out_b), 32'(mon_e.b));
            check("out_c", 32'(out_c), 32'(mon_e.c));
            check("out_d", 32'(out_d), 32'(mon_e.d));
         end
      end
      if (sync_err) n_serr++;
   end

   task automatic send_bit(input logic b, input logic fs);
      @(negedge clk);
      in_valid   = 1'b1;
      din        = b;
      frame_sync = fs;
      drive_cyc  = cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid   = 1'b0;
         din        = 1'b0;
         frame_sync = 1'b0;
      end
   endtask

   // Drive the first nbits of a frame (sync on bit 0); stall[i] inserts 3 idle cycles after bit i+1.
   task automatic send_frame(input frame_t f, input logic [63:0] stall, input int nbits,
                             input logic push);
      logic [FB-1:0] v;
      v = f;
      if (push) exp_q.push_back(f);
      for (int i = 0; i < nbits; i++) begin
         send_bit(v[FB-1-i], (i == 0));
         if (i == 0) begin
            st_cyc = drive_cyc;
            check("locked_after_sync", 32'(locked), 32'd1);
         end
         check("slot", 32'(slot), 32'(((i + 1) / W) % 4));
         if (stall[i]) idle(3);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      frame_t        f1;
      frame_t        f;
      logic [FB-1:0] tmp;
      logic [63:0]   mask;
      int            nv;
      int            ns;

      f1 = '{a: 8'hA5, b: 8'h3C, c: 8'h0F, d: 8'hF0};

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_out_d", 32'(out_d), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_slot", 32'(slot), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Lock on the first frame; out_valid one cycle after bit 32
      nv = n_valid;
      send_frame(f1, 64'd0, FB, 1'b1);
      check("s1_valid_now", 32'(out_valid), 32'd1);
      idle(3);
      check("s1_latency", 32'(valid_cyc - st_cyc), 32'(FB));
      check("s1_pulses", 32'(n_valid - nv), 32'd1);
      check("s1_hold_a", 32'(out_a), 32'hA5);
      check("s1_valid_low", 32'(out_valid), 32'd0);

      // One-hot channels
      for (int k = 0; k < 4; k++) begin
         tmp = FB'(8'hFF) << ((3 - k) * W);
         f   = tmp;
         send_frame(f, 64'd0, FB, 1'b1);
         idle(2);
      end

      // Stalls after bits 5, 12 and 31 delay out_valid by 9 cycles
      mask = 64'd0;
      mask[4]  = 1'b1;
      mask[11] = 1'b1;
      mask[30] = 1'b1;
      send_frame(f1, mask, FB, 1'b1);
      idle(3);
      check("stall_latency", 32'(valid_cyc - st_cyc), 32'(FB + 9));

      // Resync on bit 3 of slot c, then a full frame
      nv = n_valid;
      ns = n_serr;
      send_frame(f1, 64'd0, 2 * W + 3, 1'b0);
      send_frame('{a: 8'h11, b: 8'h22, c: 8'h33, d: 8'h44}, 64'd0, FB, 1'b1);
      idle(3);
      check("resync_err_pulses", 32'(n_serr - ns), 32'd1);
      check("resync_valid_pulses", 32'(n_valid - nv), 32'd1);

      // Reset mid-frame during slot b
      send_frame(f1, 64'd0, W + 3, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check("midrst_out_a", 32'(out_a), 32'd0);
      check("midrst_out_b", 32'(out_b), 32'd0);
      check("midrst_out_d", 32'(out_d), 32'd0);
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_slot", 32'(slot), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Hunting: garbage without sync, then a valid frame
      nv = n_valid;
      for (int i = 0; i < 10; i++) begin
         send_bit(1'b1, 1'b0);
         check("hunt_locked", 32'(locked), 32'd0);
      end
      send_frame('{a: 8'h5A, b: 8'hC3, c: 8'h81, d: 8'h7E}, 64'd0, FB, 1'b1);
      idle(3);
      check("hunt_pulses", 32'(n_valid - nv), 32'd1);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
